// File: rtl/line_render_scheduler.sv
// ============================================================================
//  Module   : line_render_scheduler
//  Brief    : Schedules per-line rendering into a ping-pong line buffer against
//             VGA timing; swaps halves at end of line, flags overruns, vblank IRQ.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_render_scheduler #(
    parameter int TOTAL_WIDTH   = 800,
    parameter int TOTAL_HEIGHT  = 525,
    parameter int ACTIVE_HEIGHT = 480,
    parameter int START_H       = 0,
    parameter int SWAP_H        = 799
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        render_done,
    input  logic        irq_ack,
    input  logic        underrun_clear,
    output logic        render_start,
    output logic        render_abort,
    output logic [9:0]  render_line,
    output logic        render_busy,
    output logic        read_buf,
    output logic        write_buf,
    output logic        vblank_irq,
    output logic [15:0] frame_count,
    output logic        underrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RENDER = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [9:0] c_TOTAL_W  = 10'(TOTAL_WIDTH);
    localparam logic [9:0] c_LAST_V   = 10'(TOTAL_HEIGHT - 1);
    localparam logic [9:0] c_ACTIVE_H = 10'(ACTIVE_HEIGHT);
    localparam logic [9:0] c_START_H  = 10'(START_H);
    localparam logic [9:0] c_SWAP_H   = 10'(SWAP_H);

    logic [1:0]  state_q, state_d;
    logic        armed_q, armed_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic [9:0]  line_q, line_d;
    logic        rbuf_q, rbuf_d;
    logic        und_q, und_d;
    logic        irq_q, irq_d;
    logic [15:0] fc_q, fc_d;

    logic [9:0]  w_tgt;
    logic        w_in_line;
    logic        w_trigger;
    logic        w_swap_ev;
    logic        w_vb_set;

    // The line rendered now is the one scanned out next; the last line of the
    // frame prepares line 0 of the following frame.
    assign w_tgt     = (vpos == c_LAST_V) ? 10'd0 : vpos + 10'd1;
    assign w_in_line = (hpos < c_TOTAL_W);
    assign w_trigger = w_in_line && (hpos == c_START_H) && (w_tgt < c_ACTIVE_H) && enable;
    assign w_swap_ev = w_in_line && (hpos == c_SWAP_H) && armed_q;
    assign w_vb_set  = (vpos == c_ACTIVE_H) && (hpos == 10'd0);

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        line_d  = line_q;
        rbuf_d  = rbuf_q;
        und_d   = und_q & ~underrun_clear;
        irq_d   = w_vb_set | (irq_q & ~irq_ack);
        fc_d    = fc_q + {15'd0, w_vb_set};

        case (state_q)
            S_IDLE: begin
                if (w_trigger) begin
                    state_d = S_RENDER;
                    start_d = 1'b1;
                    line_d  = w_tgt;
                    armed_d = 1'b1;
                end
            end
            S_RENDER: begin
                // A done pulse coinciding with the swap still counts as on time.
                if (w_swap_ev) begin
                    state_d = S_IDLE;
                    armed_d = 1'b0;
                    rbuf_d  = ~rbuf_q;
                    if (!render_done) begin
                        und_d   = 1'b1;
                        abort_d = 1'b1;
                    end
                end else if (render_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (w_swap_ev) begin
                    state_d = S_IDLE;
                    armed_d = 1'b0;
                    rbuf_d  = ~rbuf_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                armed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            line_q  <= 10'd0;
            rbuf_q  <= 1'b0;
            und_q   <= 1'b0;
            irq_q   <= 1'b0;
            fc_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            start_q <= start_d;
            abort_q <= abort_d;
            line_q  <= line_d;
            rbuf_q  <= rbuf_d;
            und_q   <= und_d;
            irq_q   <= irq_d;
            fc_q    <= fc_d;
        end
    end

    assign render_start = start_q;
    assign render_abort = abort_q;
    assign render_line  = line_q;
    assign render_busy  = (state_q == S_RENDER);
    assign read_buf     = rbuf_q;
    assign write_buf    = ~rbuf_q;
    assign vblank_irq   = irq_q;
    assign frame_count  = fc_q;
    assign underrun     = und_q;

endmodule

`default_nettype wire

// File: tb/tb_line_render_scheduler.sv
// ============================================================================
//  Module   : tb_line_render_scheduler
//  Brief    : Directed self-checking bench for line_render_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_render_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        render_done;
    logic        irq_ack;
    logic        underrun_clear;
    logic        render_start;
    logic        render_abort;
    logic [9:0]  render_line;
    logic        render_busy;
    logic        read_buf;
    logic        write_buf;
    logic        vblank_irq;
    logic [15:0] frame_count;
    logic        underrun;

    int checks   = 0;
    int failures = 0;

    line_render_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .hpos           (hpos),
        .vpos           (vpos),
        .render_done    (render_done),
        .irq_ack        (irq_ack),
        .underrun_clear (underrun_clear),
        .render_start   (render_start),
        .render_abort   (render_abort),
        .render_line    (render_line),
        .render_busy    (render_busy),
        .read_buf       (read_buf),
        .write_buf      (write_buf),
        .vblank_irq     (vblank_irq),
        .frame_count    (frame_count),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one timing position for one clock; outputs seen afterwards are
    // the registered response to that position.
    task automatic step(input int v, input int h, input logic done);
        vpos        = 10'(v);
        hpos        = 10'(h);
        render_done = done;
        @(posedge clk);
        #1;
        render_done = 1'b0;
    endtask

    task automatic run_line(input int v, input int done_h,
                            output int n_start, output int start_at,
                            output logic [9:0] line, output int n_abort,
                            output logic b300, output logic b302);
        n_start  = 0;
        start_at = -1;
        line     = 10'd0;
        n_abort  = 0;
        b300     = 1'b0;
        b302     = 1'b0;
        for (int h = 0; h < 800; h++) begin
            step(v, h, (h == done_h));
            if (render_start) begin
                n_start++;
                start_at = h + 1;
                line     = render_line;
            end
            if (render_abort) n_abort++;
            if (h + 1 == 300) b300 = render_busy;
            if (h + 1 == 302) b302 = render_busy;
        end
    endtask

    initial begin
        int          ns, sa, na;
        logic [9:0]  ln;
        logic        b3, b4;

        reset          = 1'b1;
        enable         = 1'b1;
        irq_ack        = 1'b0;
        underrun_clear = 1'b0;
        render_done    = 1'b0;
        step(0, 5, 1'b0);
        step(0, 5, 1'b0);
        chk("rst_start",  {31'd0, render_start}, 32'd0);
        chk("rst_abort",  {31'd0, render_abort}, 32'd0);
        chk("rst_busy",   {31'd0, render_busy},  32'd0);
        chk("rst_line",   {22'd0, render_line},  32'd0);
        chk("rst_rbuf",   {31'd0, read_buf},     32'd0);
        chk("rst_wbuf",   {31'd0, write_buf},    32'd1);
        chk("rst_irq",    {31'd0, vblank_irq},   32'd0);
        chk("rst_fc",     {16'd0, frame_count},  32'd0);
        chk("rst_und",    {31'd0, underrun},     32'd0);
        reset = 1'b0;

        // Normal line
        run_line(10, 300, ns, sa, ln, na, b3, b4);
        chk("norm_nstart",  ns, 32'd1);
        chk("norm_startat", sa, 32'd1);
        chk("norm_line",    {22'd0, ln}, 32'd11);
        chk("norm_busy300", {31'd0, b3}, 32'd1);
        chk("norm_busy302", {31'd0, b4}, 32'd0);
        chk("norm_abort",   na, 32'd0);
        chk("norm_rbuf",    {31'd0, read_buf},  32'd1);
        chk("norm_wbuf",    {31'd0, write_buf}, 32'd0);
        chk("norm_und",     {31'd0, underrun},  32'd0);

        // Frame wrap: last line prepares line 0
        run_line(524, 100, ns, sa, ln, na, b3, b4);
        chk("wrap_nstart", ns, 32'd1);
        chk("wrap_line",   {22'd0, ln}, 32'd0);
        chk("wrap_rbuf",   {31'd0, read_buf}, 32'd0);

        // Last visible line schedules nothing
        run_line(479, 100, ns, sa, ln, na, b3, b4);
        chk("v479_nstart", ns, 32'd0);
        chk("v479_rbuf",   {31'd0, read_buf}, 32'd0);

        // Underrun
        run_line(20, -1, ns, sa, ln, na, b3, b4);
        chk("und_nstart", ns, 32'd1);
        chk("und_abort",  na, 32'd1);
        chk("und_flag",   {31'd0, underrun},    32'd1);
        chk("und_rbuf",   {31'd0, read_buf},    32'd1);
        chk("und_idle",   {31'd0, render_busy}, 32'd0);
        underrun_clear = 1'b1;
        step(21, 5, 1'b0);
        underrun_clear = 1'b0;
        chk("und_clear",  {31'd0, underrun}, 32'd0);

        // Done coincident with swap
        run_line(30, 799, ns, sa, ln, na, b3, b4);
        chk("coin_abort", na, 32'd0);
        chk("coin_und",   {31'd0, underrun}, 32'd0);
        chk("coin_rbuf",  {31'd0, read_buf}, 32'd0);

        // enable low across a line
        enable = 1'b0;
        run_line(40, 300, ns, sa, ln, na, b3, b4);
        enable = 1'b1;
        chk("dis_nstart", ns, 32'd0);
        chk("dis_rbuf",   {31'd0, read_buf}, 32'd0);

        // vblank set and ack together: set wins
        irq_ack = 1'b1;
        step(480, 0, 1'b0);
        chk("vb_set_ack", {31'd0, vblank_irq}, 32'd1);
        chk("vb_fc1",     {16'd0, frame_count}, 32'd1);
        step(480, 5, 1'b0);
        irq_ack = 1'b0;
        chk("vb_acked",   {31'd0, vblank_irq}, 32'd0);
        step(480, 0, 1'b0);
        chk("vb_fc2",     {16'd0, frame_count}, 32'd2);

        // Reset in the middle of a render
        for (int h = 0; h < 200; h++) step(50, h, 1'b0);
        chk("mid_busy", {31'd0, render_busy}, 32'd1);
        reset = 1'b1;
        step(50, 200, 1'b0);
        chk("mrst_start", {31'd0, render_start}, 32'd0);
        chk("mrst_abort", {31'd0, render_abort}, 32'd0);
        chk("mrst_busy",  {31'd0, render_busy},  32'd0);
        chk("mrst_line",  {22'd0, render_line},  32'd0);
        chk("mrst_irq",   {31'd0, vblank_irq},   32'd0);
        chk("mrst_fc",    {16'd0, frame_count},  32'd0);
        chk("mrst_rbuf",  {31'd0, read_buf},     32'd0);
        reset = 1'b0;
        // Armed flag was dropped: no swap at end of this line
        for (int h = 201; h < 800; h++) step(50, h, 1'b0);
        chk("mrst_noswap", {31'd0, read_buf}, 32'd0);
        chk("mrst_noabt",  {31'd0, render_abort}, 32'd0);

        // Frame counter wrap
        for (int i = 0; i < 65535; i++) step(480, 0, 1'b0);
        chk("fc_ffff", {16'd0, frame_count}, 32'h0000FFFF);
        step(480, 0, 1'b0);
        chk("fc_wrap", {16'd0, frame_count}, 32'd0);
        chk("fc_irq",  {31'd0, vblank_irq},  32'd1);
        irq_ack = 1'b1;
        step(480, 5, 1'b0);
        irq_ack = 1'b0;
        chk("fc_ack",  {31'd0, vblank_irq},  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
